// File: rtl/zuc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zuc_pkg
//  Description : Shared constants, types and helpers for the ZUC LFSR block.
//                D load constants, modulus 2^31-1, control state encoding and
//                the 31-bit rotate that implements multiplication by 2^k.
//  Revision    : 1.0  initial release
// ============================================================================
package zuc_pkg;

    // Modulus p = 2^31 - 1; also the stand-in written for a zero result.
    localparam logic [30:0] P_MOD = 31'h7FFFFFFF;

    // 15-bit load constants D_0 .. D_15 (element 0 is the leftmost).
    localparam logic [0:15][14:0] C_D = {
        15'h44D7, 15'h26BC, 15'h626B, 15'h135E,
        15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
        15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1,
        15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
    };

    // Control states, explicitly encoded in three bits.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_WORK0 = 3'd3,
        ST_RUN   = 3'd4
    } zuc_state_e;

    // Multiplication by 2^k modulo 2^31-1 is a 31-bit rotate-left by k.
    function automatic logic [30:0] rotl31(input logic [30:0] x, input int unsigned k);
        return (x << k) | (x >> (31 - k));
    endfunction

endpackage
`default_nettype wire

// File: rtl/zuc_lfsr_if.sv
`default_nettype none
// ============================================================================
//  Module      : zuc_lfsr_if
//  Description : Tap bus between the ZUC LFSR (master) and its consumers
//                (nonlinear FSM / bit reconstruction, slave).
//                master in : start, key, iv, w_in, step_req
//                master out: ready, init_phase, lfsr_adv, s15_o..s0_o taps
//  Revision    : 1.0  initial release
// ============================================================================
interface zuc_lfsr_if;

    logic         start;
    logic [127:0] key;
    logic [127:0] iv;
    logic [31:0]  w_in;
    logic         step_req;

    logic         ready;
    logic         init_phase;
    logic         lfsr_adv;

    logic [30:0]  s15_o;
    logic [30:0]  s14_o;
    logic [30:0]  s11_o;
    logic [30:0]  s9_o;
    logic [30:0]  s7_o;
    logic [30:0]  s5_o;
    logic [30:0]  s2_o;
    logic [30:0]  s0_o;

    modport master (
        input  start, key, iv, w_in, step_req,
        output ready, init_phase, lfsr_adv,
        output s15_o, s14_o, s11_o, s9_o, s7_o, s5_o, s2_o, s0_o
    );

    modport slave (
        output start, key, iv, w_in, step_req,
        input  ready, init_phase, lfsr_adv,
        input  s15_o, s14_o, s11_o, s9_o, s7_o, s5_o, s2_o, s0_o
    );

endinterface
`default_nettype wire

// File: rtl/zuc_add_mod_p.sv
`default_nettype none
// ============================================================================
//  Module      : zuc_add_mod_p
//  Description : Combinational addition modulo 2^31-1.
//                i_a, i_b : operands in [0, p]
//                o_sum    : (i_a + i_b) mod p, in [0, p]
//  Revision    : 1.0  initial release
// ============================================================================
module zuc_add_mod_p (
    input  logic [30:0] i_a,
    input  logic [30:0] i_b,
    output logic [30:0] o_sum
);

    logic [31:0] w_raw;

    // 2^31 == 1 (mod p), so the carry folds back into bit 0. With both
    // operands <= p the folded result cannot carry again.
    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = w_raw[30:0] + {30'd0, w_raw[31]};

endmodule
`default_nettype wire

// File: rtl/zuc_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : zuc_lfsr
//  Description : ZUC 16 x 31-bit LFSR, producer side of the tap bus.
//                Loads key/IV, runs INIT_ROUNDS init-mode shifts folding in
//                u = W>>1, one discarded work shift, then one work shift per
//                accepted step_req.
//                clk   : clock, rising edge
//                rst_n : synchronous active-low reset
//                tap   : zuc_lfsr_if.master (control in, taps/strobes out)
//  Revision    : 1.0  initial release
// ============================================================================
module zuc_lfsr #(
    parameter int INIT_ROUNDS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    zuc_lfsr_if.master     tap
);

    import zuc_pkg::*;

    localparam int              CNT_W      = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(INIT_ROUNDS - 1);

    zuc_state_e        r_state;
    zuc_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [30:0]       r_s [16];

    logic [30:0]       w_load_val [16];
    logic              w_load;
    logic              w_adv;
    logic              w_init_mode;
    logic              w_ready;

    logic [30:0]       w_a0, w_a1, w_a2, w_a3;
    logic [30:0]       w_v;
    logic [30:0]       w_u;
    logic [30:0]       w_sum;
    logic [30:0]       w_s16;
    logic              w_unused_ok;

    // ------------------------------------------------------------------
    // State register and init-round counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (tap.start) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_INIT;
            ST_INIT:  if (r_cnt == C_CNT_LAST) w_state_nxt = ST_WORK0;
            ST_WORK0: w_state_nxt = ST_RUN;
            ST_RUN:   if (tap.start) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs. A reload in RUN takes priority over a step,
    // so the advance strobe is withheld in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready     = (r_state == ST_RUN);
        w_init_mode = (r_state == ST_INIT);
        w_load      = tap.start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
        w_adv       = (r_state == ST_INIT) || (r_state == ST_WORK0) ||
                      ((r_state == ST_RUN) && tap.step_req && !tap.start);
    end

    // ------------------------------------------------------------------
    // Load values: s_i = {k_i, D_i, iv_i}
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_load
            assign w_load_val[gi] = {tap.key[127 - 8*gi -: 8], C_D[gi], tap.iv[127 - 8*gi -: 8]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Feedback: v = 2^15 s15 + 2^17 s13 + 2^21 s10 + 2^20 s4 + (1+2^8) s0
    // ------------------------------------------------------------------
    zuc_add_mod_p u_add0 (.i_a(rotl31(r_s[15], 15)), .i_b(rotl31(r_s[13], 17)), .o_sum(w_a0));
    zuc_add_mod_p u_add1 (.i_a(rotl31(r_s[10], 21)), .i_b(rotl31(r_s[4], 20)),  .o_sum(w_a1));
    zuc_add_mod_p u_add2 (.i_a(rotl31(r_s[0], 8)),   .i_b(r_s[0]),               .o_sum(w_a2));
    zuc_add_mod_p u_add3 (.i_a(w_a0),                .i_b(w_a1),                 .o_sum(w_a3));
    zuc_add_mod_p u_add4 (.i_a(w_a3),                .i_b(w_a2),                 .o_sum(w_v));

    // Work mode adds zero, which leaves v unchanged since v <= p.
    assign w_u = w_init_mode ? tap.w_in[31:1] : 31'd0;

    zuc_add_mod_p u_add5 (.i_a(w_v), .i_b(w_u), .o_sum(w_sum));

    // Zero is never written into the register; p stands for it.
    assign w_s16 = (w_sum == 31'd0) ? P_MOD : w_sum;

    // The W LSB is dropped by the >>1 fold.
    assign w_unused_ok = tap.w_in[0];

    // ------------------------------------------------------------------
    // Cell register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_s[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_s[i] <= w_load_val[i];
            end
        end else if (w_adv) begin
            for (int i = 0; i < 15; i++) begin
                r_s[i] <= r_s[i+1];
            end
            r_s[15] <= w_s16;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tap.ready      = w_ready;
    assign tap.init_phase = w_init_mode;
    assign tap.lfsr_adv   = w_adv;

    assign tap.s15_o = r_s[15];
    assign tap.s14_o = r_s[14];
    assign tap.s11_o = r_s[11];
    assign tap.s9_o  = r_s[9];
    assign tap.s7_o  = r_s[7];
    assign tap.s5_o  = r_s[5];
    assign tap.s2_o  = r_s[2];
    assign tap.s0_o  = r_s[0];

endmodule
`default_nettype wire

// File: tb/tb_zuc_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zuc_lfsr
//  Description : Self-checking bench for zuc_lfsr. Load-rule vectors from a
//                hand-computed table, plus directed sequences for init
//                latency, mod-p boundaries, RUN stepping, reload and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zuc_lfsr;

    localparam int          ROUNDS = 32;
    localparam logic [30:0] P      = 31'h7FFFFFFF;

    logic clk;
    logic rst_n;

    zuc_lfsr_if bus ();

    zuc_lfsr #(.INIT_ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tap   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [30:0] m_s  [16];
    logic [14:0] tb_d [16];

    typedef struct {
        logic [127:0] key;
        logic [127:0] iv;
        logic [30:0]  s0;
        logic [30:0]  s2;
        logic [30:0]  s7;
        logic [30:0]  s15;
    } load_vec_t;

    load_vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic uses 64-bit integers and the % operator.
    function automatic longint mulpow(input logic [30:0] x, input int k);
        return (longint'(x) << k) % longint'(P);
    endfunction

    function automatic logic [30:0] model_v();
        longint t;
        t = mulpow(m_s[15], 15) + mulpow(m_s[13], 17) + mulpow(m_s[10], 21)
          + mulpow(m_s[4], 20) + longint'(m_s[0]) * 257;
        return 31'(t % longint'(P));
    endfunction

    task automatic model_step(input bit init, input logic [31:0] w);
        longint t;
        t = longint'(model_v());
        if (init) t = t + longint'(w >> 1);
        t = t % longint'(P);
        if (t == 0) t = longint'(P);
        for (int i = 0; i < 15; i++) m_s[i] = m_s[i+1];
        m_s[15] = 31'(t);
    endtask

    task automatic model_load(input logic [127:0] key, input logic [127:0] iv);
        for (int i = 0; i < 16; i++)
            m_s[i] = {key[127 - 8*i -: 8], tb_d[i], iv[127 - 8*i -: 8]};
    endtask

    task automatic model_clear;
        for (int i = 0; i < 16; i++) m_s[i] = '0;
    endtask

    task automatic check_taps(input string tag);
        chk({tag, "_s15"}, bus.s15_o, m_s[15]);
        chk({tag, "_s14"}, bus.s14_o, m_s[14]);
        chk({tag, "_s11"}, bus.s11_o, m_s[11]);
        chk({tag, "_s9"},  bus.s9_o,  m_s[9]);
        chk({tag, "_s7"},  bus.s7_o,  m_s[7]);
        chk({tag, "_s5"},  bus.s5_o,  m_s[5]);
        chk({tag, "_s2"},  bus.s2_o,  m_s[2]);
        chk({tag, "_s0"},  bus.s0_o,  m_s[0]);
    endtask

    task automatic check_flags(input string tag, input bit rdy, input bit ini, input bit adv);
        chk({tag, "_ready"},      bus.ready,      rdy);
        chk({tag, "_init_phase"}, bus.init_phase, ini);
        chk({tag, "_lfsr_adv"},   bus.lfsr_adv,   adv);
    endtask

    // Start from IDLE/RUN and follow the block into RUN, checking latency,
    // strobes, the mod-p boundaries on the first two init shifts, and that
    // a start pulse mid-INIT is ignored.
    task automatic run_full(input logic [127:0] key, input logic [127:0] iv, input string tag);
        int          cyc;
        int          n_init;
        logic [30:0] v;
        logic [30:0] u;
        bus.key      = key;
        bus.iv       = iv;
        bus.start    = 1'b1;
        bus.step_req = 1'b0;
        tick;
        cyc = 1;
        model_load(key, iv);
        bus.start = 1'b0;
        check_taps({tag, "_load"});
        check_flags({tag, "_load"}, 1'b0, 1'b0, 1'b0);
        tick;
        cyc++;
        n_init = 0;
        while (bus.init_phase && n_init < ROUNDS + 8) begin
            if (n_init == 0) begin
                v = model_v();
                u = P - v;                      // v + u == p
                bus.w_in = {u, 1'b0};
            end else if (n_init == 1) begin
                v = model_v();
                u = P - v + 31'd1;              // v + u == p + 1
                bus.w_in = {u, 1'b1};
            end else begin
                bus.w_in = 32'h9E3779B9 ^ (32'(n_init) * 32'h01000193);
            end
            if (n_init == 5) begin
                bus.start = 1'b1;
                bus.key   = ~key;
            end
            #1;
            chk({tag, "_init_adv"}, bus.lfsr_adv, 1'b1);
            model_step(1'b1, bus.w_in);
            tick;
            cyc++;
            bus.start = 1'b0;
            bus.key   = key;
            if (n_init == 0) chk({tag, "_modp_eq_p"},  bus.s15_o, 31'h7FFFFFFF);
            if (n_init == 1) chk({tag, "_modp_p_plus1"}, bus.s15_o, 31'd1);
            n_init++;
        end
        chk({tag, "_init_rounds"}, n_init, ROUNDS);
        check_flags({tag, "_work0"}, 1'b0, 1'b0, 1'b1);
        bus.w_in = 32'hFFFFFFFF;                // must not affect a work step
        model_step(1'b0, 32'h0);
        tick;
        cyc++;
        chk({tag, "_latency"}, cyc, 1 + ROUNDS + 1 + 1);
        check_flags({tag, "_run"}, 1'b1, 1'b0, 1'b0);
        check_taps({tag, "_run"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pat [3];
        logic [127:0] key2;
        logic [127:0] iv2;

        tb_d = '{15'h44D7, 15'h26BC, 15'h626B, 15'h135E,
                 15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
                 15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1,
                 15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC};

        vecs[0] = '{128'h0, 128'h0,
                    31'h0044D700, 31'h00626B00, 31'h0009AF00, 31'h0047AC00};
        vecs[1] = '{{128{1'b1}}, 128'h0,
                    31'h7FC4D700, 31'h7FE26B00, 31'h7F89AF00, 31'h7FC7AC00};
        vecs[2] = '{128'h0, {128{1'b1}},
                    31'h0044D7FF, 31'h00626BFF, 31'h0009AFFF, 31'h0047ACFF};
        vecs[3] = '{128'h000102030405060708090A0B0C0D0E0F,
                    128'hF0E0D0C0B0A090807060504030201000,
                    31'h0044D7F0, 31'h01626BD0, 31'h0389AF80, 31'h07C7AC00};

        key2 = 128'h3D4C4BE96A82FDAEB58F641DB17B455B;
        iv2  = 128'h84319AA8DE6915CA1F6BDA6BFBD8C766;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.iv       = '0;
        bus.w_in     = '0;
        bus.step_req = 1'b0;
        tick;
        tick;
        model_clear();
        check_taps("reset");
        check_flags("reset", 1'b0, 1'b0, 1'b0);

        // IDLE ignores step requests.
        rst_n        = 1'b1;
        bus.step_req = 1'b1;
        #1;
        chk("idle_adv", bus.lfsr_adv, 1'b0);
        tick;
        check_taps("idle_hold");
        bus.step_req = 1'b0;

        // Load-rule table.
        for (int k = 0; k < 4; k++) begin
            bus.key   = vecs[k].key;
            bus.iv    = vecs[k].iv;
            bus.start = 1'b1;
            tick;
            bus.start = 1'b0;
            chk($sformatf("vec%0d_s0", k),  bus.s0_o,  vecs[k].s0);
            chk($sformatf("vec%0d_s2", k),  bus.s2_o,  vecs[k].s2);
            chk($sformatf("vec%0d_s7", k),  bus.s7_o,  vecs[k].s7);
            chk($sformatf("vec%0d_s15", k), bus.s15_o, vecs[k].s15);
            chk($sformatf("vec%0d_init", k), bus.init_phase, 1'b0);
            rst_n = 1'b0;
            tick;
            rst_n = 1'b1;
        end

        run_full(128'h0, 128'h0, "zero");

        // RUN stepping: 1,0,1 gives exactly two shifts.
        pat = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            bus.step_req = pat[k];
            bus.w_in     = 32'h13579BDF + 32'(k);
            #1;
            chk($sformatf("run_adv%0d", k), bus.lfsr_adv, pat[k]);
            if (pat[k]) model_step(1'b0, 32'h0);
            tick;
            check_taps($sformatf("run_step%0d", k));
        end
        bus.step_req = 1'b0;
        chk("run_ready_hold", bus.ready, 1'b1);

        // Reload in RUN with a simultaneous step request: load wins.
        bus.key      = key2;
        bus.iv       = iv2;
        bus.start    = 1'b1;
        bus.step_req = 1'b1;
        tick;
        model_load(key2, iv2);
        bus.start    = 1'b0;
        bus.step_req = 1'b0;
        check_taps("reload");
        chk("reload_ready", bus.ready, 1'b0);

        // Reset in the middle of INIT.
        tick;
        for (int k = 0; k < 4; k++) begin
            bus.w_in = 32'hA5A5F00F ^ 32'(k);
            model_step(1'b1, bus.w_in);
            tick;
        end
        check_taps("midinit");
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        model_clear();
        check_taps("midinit_rst");
        check_flags("midinit_rst", 1'b0, 1'b0, 1'b0);

        run_full(key2, iv2, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
